// File: rtl/palette_lookup.sv
// Palette lookup stage ahead of the colour encoder.
// Converts an 11-bit pixel index plus sideband into 5:5:5 RGB and encoder
// control bits through a 2048x16 single-port palette RAM. CPU palette writes
// are held in a one-entry buffer and drained into blanked pixel slots. If the
// video stays active too long, the buffer steals one active slot instead.
// Pixel inputs sampled on edge n reach the outputs after edge n+2.

module palette_lookup #(
    parameter int STARVE_MAX = 8,
    parameter int IDX_W      = 11
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [IDX_W-1:0] PIX_IDX,
    input  logic             PIX_NBLANK,
    input  logic             PIX_SHADE,
    input  logic             PIX_HILITE,
    input  logic             CPU_WR,
    input  logic [IDX_W-1:0] CPU_ADDR,
    input  logic [15:0]      CPU_DATA,
    output logic             CPU_BUSY,
    input  logic             CTRL_WR,
    input  logic             CTRL_GREY,
    output logic [4:0]       R,
    output logic [4:0]       G,
    output logic [4:0]       B,
    output logic             nBLANK,
    output logic             nSHADE,
    output logic             HI_LO,
    output logic             nGREY
);

    localparam int         DEPTH      = 1 << IDX_W;
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_PENDING = 1'b1
    } wb_state_t;

    // Expand a packed palette word into {R, G, B}; the colour LSBs live in bits 14:12.
    function automatic logic [14:0] unpack_rgb(input logic [15:0] w);
        unpack_rgb = {w[3:0], w[12], w[7:4], w[13], w[11:8], w[14]};
    endfunction

    // ------------------------------------------------------------------
    // Write buffer state
    // ------------------------------------------------------------------
    wb_state_t        state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] wb_addr_q, wb_addr_d;
    logic [15:0]      wb_data_q, wb_data_d;
    logic             busy_q, busy_d;

    logic             drain_s;
    logic             ram_we_s;
    logic             ram_re_s;

    // ------------------------------------------------------------------
    // Palette RAM and pipeline registers
    // ------------------------------------------------------------------
    logic [15:0]      mem_q [DEPTH];
    logic [15:0]      ram_rd_q;

    logic             s1_word_vld_q, s1_word_vld_d;
    logic             s1_nblank_q, s1_nblank_d;
    logic             s1_shade_q, s1_shade_d;
    logic             s1_hilite_q, s1_hilite_d;
    logic             s1_stolen_q, s1_stolen_d;

    logic [15:0]      word_s;
    logic             shade_s;
    logic [14:0]      rgb_s;

    logic [4:0]       s2_r_q, s2_r_d;
    logic [4:0]       s2_g_q, s2_g_d;
    logic [4:0]       s2_b_q, s2_b_d;
    logic             s2_nblank_q, s2_nblank_d;
    logic             s2_nshade_q, s2_nshade_d;
    logic             s2_hilo_q, s2_hilo_d;
    logic             s2_stolen_q, s2_stolen_d;

    logic [4:0]       r_q, r_d;
    logic [4:0]       g_q, g_d;
    logic [4:0]       b_q, b_d;
    logic             nblank_q, nblank_d;
    logic             nshade_q, nshade_d;
    logic             hilo_q, hilo_d;
    logic             ngrey_q, ngrey_d;

    // Decide whether the pending write takes the RAM port this cycle.
    always_comb begin
        drain_s  = 1'b0;
        ram_we_s = 1'b0;
        ram_re_s = 1'b0;
        if (state_q == ST_PENDING) begin
            drain_s = (PIX_NBLANK == 1'b0) || (cnt_q == STARVE_LIM);
        end else begin
            drain_s = 1'b0;
        end
        ram_we_s = drain_s & ~RESET;
        ram_re_s = PIX_NBLANK & ~drain_s & ~RESET;
    end

    // Write buffer next state: latch when empty, drain or count starvation when pending.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        case (state_q)
            ST_EMPTY: begin
                if (CPU_WR) begin
                    state_d   = ST_PENDING;
                    wb_addr_d = CPU_ADDR;
                    wb_data_d = CPU_DATA;
                    cnt_d     = 8'd0;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_PENDING: begin
                // A strobe arriving here is dropped; the buffer holds its contents.
                if (drain_s) begin
                    state_d = ST_EMPTY;
                    cnt_d   = 8'd0;
                end else if (PIX_NBLANK) begin
                    if (cnt_q < STARVE_LIM) begin
                        cnt_d = cnt_q + 8'd1;
                    end else begin
                        cnt_d = STARVE_LIM;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                cnt_d   = 8'd0;
            end
        endcase
        busy_d = (state_d == ST_PENDING);
    end

    // Write buffer registers; reset discards any pending write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_EMPTY;
            cnt_q     <= 8'd0;
            wb_addr_q <= '0;
            wb_data_q <= 16'h0000;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            busy_q    <= busy_d;
        end
    end

    // Single-port palette RAM: a drain write replaces the pixel read; contents are never reset.
    always_ff @(posedge CLK) begin
        if (ram_we_s) begin
            mem_q[wb_addr_q] <= wb_data_q;
        end else if (ram_re_s) begin
            ram_rd_q <= mem_q[PIX_IDX];
        end else begin
            ram_rd_q <= ram_rd_q;
        end
    end

    // Stage 1 sideband accompanying the RAM read.
    always_comb begin
        s1_word_vld_d = ram_re_s;
        s1_nblank_d   = PIX_NBLANK;
        s1_shade_d    = PIX_SHADE;
        s1_hilite_d   = PIX_HILITE;
        s1_stolen_d   = PIX_NBLANK & drain_s;
    end

    // Stage 1 registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_word_vld_q <= 1'b0;
            s1_nblank_q   <= 1'b0;
            s1_shade_q    <= 1'b0;
            s1_hilite_q   <= 1'b0;
            s1_stolen_q   <= 1'b0;
        end else begin
            s1_word_vld_q <= s1_word_vld_d;
            s1_nblank_q   <= s1_nblank_d;
            s1_shade_q    <= s1_shade_d;
            s1_hilite_q   <= s1_hilite_d;
            s1_stolen_q   <= s1_stolen_d;
        end
    end

    // Stage 2 unpack: blanked and stolen pixels see a zero word.
    always_comb begin
        if (s1_word_vld_q) begin
            word_s = ram_rd_q;
        end else begin
            word_s = 16'h0000;
        end
        shade_s     = s1_shade_q | word_s[15];
        rgb_s       = unpack_rgb(word_s);
        s2_r_d      = rgb_s[14:10];
        s2_g_d      = rgb_s[9:5];
        s2_b_d      = rgb_s[4:0];
        s2_nblank_d = s1_nblank_q;
        s2_nshade_d = ~shade_s;
        // Shadow takes priority over highlight.
        s2_hilo_d   = s1_hilite_q & ~shade_s;
        s2_stolen_d = s1_stolen_q;
    end

    // Stage 2 registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s2_r_q      <= 5'd0;
            s2_g_q      <= 5'd0;
            s2_b_q      <= 5'd0;
            s2_nblank_q <= 1'b0;
            s2_nshade_q <= 1'b1;
            s2_hilo_q   <= 1'b0;
            s2_stolen_q <= 1'b0;
        end else begin
            s2_r_q      <= s2_r_d;
            s2_g_q      <= s2_g_d;
            s2_b_q      <= s2_b_d;
            s2_nblank_q <= s2_nblank_d;
            s2_nshade_q <= s2_nshade_d;
            s2_hilo_q   <= s2_hilo_d;
            s2_stolen_q <= s2_stolen_d;
        end
    end

    // Output stage: a stolen slot repeats the last colour; grey follows the control write.
    always_comb begin
        if (s2_stolen_q) begin
            r_d = r_q;
            g_d = g_q;
            b_d = b_q;
        end else begin
            r_d = s2_r_q;
            g_d = s2_g_q;
            b_d = s2_b_q;
        end
        nblank_d = s2_nblank_q;
        nshade_d = s2_nshade_q;
        hilo_d   = s2_hilo_q;
        if (CTRL_WR) begin
            ngrey_d = ~CTRL_GREY;
        end else begin
            ngrey_d = ngrey_q;
        end
    end

    // Output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_q      <= 5'd0;
            g_q      <= 5'd0;
            b_q      <= 5'd0;
            nblank_q <= 1'b0;
            nshade_q <= 1'b1;
            hilo_q   <= 1'b0;
            ngrey_q  <= 1'b1;
        end else begin
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            nblank_q <= nblank_d;
            nshade_q <= nshade_d;
            hilo_q   <= hilo_d;
            ngrey_q  <= ngrey_d;
        end
    end

    assign R        = r_q;
    assign G        = g_q;
    assign B        = b_q;
    assign nBLANK   = nblank_q;
    assign nSHADE   = nshade_q;
    assign HI_LO    = hilo_q;
    assign nGREY    = ngrey_q;
    assign CPU_BUSY = busy_q;

endmodule

// File: tb/tb_palette_lookup.sv
// Testbench for palette_lookup: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the palette stage.

module tb_palette_lookup;

    localparam int STARVE = 8;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [10:0] PIX_IDX;
    logic        PIX_NBLANK, PIX_SHADE, PIX_HILITE;
    logic        CPU_WR;
    logic [10:0] CPU_ADDR;
    logic [15:0] CPU_DATA;
    logic        CPU_BUSY;
    logic        CTRL_WR, CTRL_GREY;
    logic [4:0]  R, G, B;
    logic        nBLANK, nSHADE, HI_LO, nGREY;

    palette_lookup #(.STARVE_MAX(STARVE), .IDX_W(11)) dut (
        .CLK(CLK), .RESET(RESET), .PIX_IDX(PIX_IDX), .PIX_NBLANK(PIX_NBLANK),
        .PIX_SHADE(PIX_SHADE), .PIX_HILITE(PIX_HILITE), .CPU_WR(CPU_WR),
        .CPU_ADDR(CPU_ADDR), .CPU_DATA(CPU_DATA), .CPU_BUSY(CPU_BUSY),
        .CTRL_WR(CTRL_WR), .CTRL_GREY(CTRL_GREY), .R(R), .G(G), .B(B),
        .nBLANK(nBLANK), .nSHADE(nSHADE), .HI_LO(HI_LO), .nGREY(nGREY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [4:0] r;
        logic [4:0] g;
        logic [4:0] b;
        logic       nblank;
        logic       nshade;
        logic       hilo;
    } res_t;

    localparam res_t RES_RESET = '{r: 5'd0, g: 5'd0, b: 5'd0, nblank: 1'b0, nshade: 1'b1, hilo: 1'b0};

    // Behavioural model state
    logic [15:0] m_mem [2048];
    res_t        pipe [3];
    bit          m_pending;
    int          m_cnt;
    logic [10:0] m_addr;
    logic [15:0] m_data;
    logic        m_ngrey;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock edge of the palette stage described in plain terms.
    task automatic model_edge();
        res_t        nr;
        logic [15:0] w;
        bit          drain;
        bit          was_pending;
        if (RESET) begin
            m_pending = 0;
            m_cnt     = 0;
            m_ngrey   = 1'b1;
            for (int i = 0; i < 3; i++) pipe[i] = RES_RESET;
        end else begin
            was_pending = m_pending;
            drain = m_pending && (!PIX_NBLANK || m_cnt == STARVE);
            w = 16'h0000;
            if (PIX_NBLANK && !drain) w = m_mem[PIX_IDX];
            nr.r      = 5'((w & 16'h000F) * 2 + ((w >> 12) & 16'h1));
            nr.g      = 5'(((w >> 4) & 16'h000F) * 2 + ((w >> 13) & 16'h1));
            nr.b      = 5'(((w >> 8) & 16'h000F) * 2 + ((w >> 14) & 16'h1));
            if (PIX_NBLANK && drain) begin
                nr.r = pipe[0].r;
                nr.g = pipe[0].g;
                nr.b = pipe[0].b;
            end
            nr.nblank = PIX_NBLANK;
            nr.nshade = !(PIX_SHADE || w[15]);
            nr.hilo   = PIX_HILITE && !(PIX_SHADE || w[15]);
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nr;
            if (drain) begin
                m_mem[m_addr] = m_data;
                m_pending = 0;
                m_cnt = 0;
            end else if (m_pending && PIX_NBLANK) begin
                m_cnt = (m_cnt < STARVE) ? m_cnt + 1 : STARVE;
            end
            if (!was_pending && CPU_WR) begin
                m_pending = 1;
                m_addr = CPU_ADDR;
                m_data = CPU_DATA;
                m_cnt = 0;
            end
            if (CTRL_WR) m_ngrey = !CTRL_GREY;
        end
    endtask

    task automatic compare_outputs();
        chk("R", {11'd0, R}, {11'd0, pipe[2].r});
        chk("G", {11'd0, G}, {11'd0, pipe[2].g});
        chk("B", {11'd0, B}, {11'd0, pipe[2].b});
        chk("nBLANK", {15'd0, nBLANK}, {15'd0, pipe[2].nblank});
        chk("nSHADE", {15'd0, nSHADE}, {15'd0, pipe[2].nshade});
        chk("HI_LO", {15'd0, HI_LO}, {15'd0, pipe[2].hilo});
        chk("nGREY", {15'd0, nGREY}, {15'd0, m_ngrey});
        chk("CPU_BUSY", {15'd0, CPU_BUSY}, {15'd0, m_pending});
    endtask

    task automatic tick(input logic rst, input logic nb, input logic [10:0] idx,
                        input logic sh, input logic hl, input logic wr,
                        input logic [10:0] wa, input logic [15:0] wd,
                        input logic cw, input logic cg);
        RESET = rst; PIX_NBLANK = nb; PIX_IDX = idx; PIX_SHADE = sh; PIX_HILITE = hl;
        CPU_WR = wr; CPU_ADDR = wa; CPU_DATA = wd; CTRL_WR = cw; CTRL_GREY = cg;
        @(posedge CLK);
        model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic px(input logic nb, input logic [10:0] idx, input logic sh, input logic hl);
        tick(1'b0, nb, idx, sh, hl, 1'b0, 11'd0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic wr_blank(input logic [10:0] a, input logic [15:0] d);
        tick(1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 1'b1, a, d, 1'b0, 1'b0);
        px(1'b0, 11'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_rgb(input string name, input logic [4:0] er, input logic [4:0] eg, input logic [4:0] eb);
        chk({name, "_R"}, {11'd0, R}, {11'd0, er});
        chk({name, "_G"}, {11'd0, G}, {11'd0, eg});
        chk({name, "_B"}, {11'd0, B}, {11'd0, eb});
    endtask

    initial begin
        int busy_cycles;
        m_pending = 0; m_cnt = 0; m_addr = 11'd0; m_data = 16'h0000; m_ngrey = 1'b1;
        for (int i = 0; i < 3; i++) pipe[i] = RES_RESET;
        for (int i = 0; i < 2048; i++) m_mem[i] = 16'h0000;

        // Reset state
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 11'd3, 1'b1, 1'b1, 1'b0, 11'd0, 16'h0000, 1'b0, 1'b0);
        chk("rst_R", {11'd0, R}, 16'd0);
        chk("rst_nBLANK", {15'd0, nBLANK}, 16'd0);
        chk("rst_nSHADE", {15'd0, nSHADE}, 16'd1);
        chk("rst_HI_LO", {15'd0, HI_LO}, 16'd0);
        chk("rst_nGREY", {15'd0, nGREY}, 16'd1);
        chk("rst_BUSY", {15'd0, CPU_BUSY}, 16'd0);

        // Fill the working range of the palette
        for (int i = 0; i < 64; i++) wr_blank(11'(i), 16'($urandom));

        // Latency and full-white word
        wr_blank(11'd5, 16'h7FFF);
        px(1'b1, 11'd5, 1'b0, 1'b0);
        px(1'b0, 11'd0, 1'b0, 1'b0);
        chk("lat_early_nBLANK", {15'd0, nBLANK}, 16'd0);
        px(1'b0, 11'd0, 1'b0, 1'b0);
        chk_rgb("white", 5'd31, 5'd31, 5'd31);
        chk("white_nSHADE", {15'd0, nSHADE}, 16'd1);
        chk("white_HI_LO", {15'd0, HI_LO}, 16'd0);
        chk("white_nBLANK", {15'd0, nBLANK}, 16'd1);

        // Shade beats highlight
        wr_blank(11'd9, 16'h8000);
        px(1'b1, 11'd9, 1'b0, 1'b1);
        px(1'b0, 11'd0, 1'b0, 1'b0);
        px(1'b0, 11'd0, 1'b0, 1'b0);
        chk("sh_nSHADE", {15'd0, nSHADE}, 16'd0);
        chk("sh_HI_LO", {15'd0, HI_LO}, 16'd0);
        wr_blank(11'd9, 16'h0000);
        px(1'b1, 11'd9, 1'b0, 1'b1);
        px(1'b0, 11'd0, 1'b0, 1'b0);
        px(1'b0, 11'd0, 1'b0, 1'b0);
        chk("hl_nSHADE", {15'd0, nSHADE}, 16'd1);
        chk("hl_HI_LO", {15'd0, HI_LO}, 16'd1);

        // Blank drain with read-after-write
        tick(1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 1'b1, 11'd20, 16'h1234, 1'b0, 1'b0);
        chk("bd_busy_hi", {15'd0, CPU_BUSY}, 16'd1);
        px(1'b0, 11'd0, 1'b0, 1'b0);
        chk("bd_busy_lo", {15'd0, CPU_BUSY}, 16'd0);
        px(1'b1, 11'd20, 1'b0, 1'b0);
        px(1'b0, 11'd0, 1'b0, 1'b0);
        px(1'b0, 11'd0, 1'b0, 1'b0);
        chk_rgb("raw", 5'd9, 5'd6, 5'd4);

        // Starvation: continuous active video, slot stolen at k+9
        busy_cycles = 0;
        for (int i = 0; i < 14; i++) begin
            tick(1'b0, 1'b1, (i == 9) ? 11'd20 : 11'd5, 1'b0, 1'b0, (i == 0),
                 11'd30, 16'h0421, 1'b0, 1'b0);
            if (CPU_BUSY) busy_cycles++;
            if (i == 11) begin
                chk_rgb("stolen", 5'd31, 5'd31, 5'd31);
                chk("stolen_nBLANK", {15'd0, nBLANK}, 16'd1);
            end
        end
        chk("starve_busy_cycles", 16'(busy_cycles), 16'd9);

        // Dropped second write
        wr_blank(11'd41, 16'h0000);
        wr_blank(11'd42, 16'h0000);
        tick(1'b0, 1'b1, 11'd5, 1'b0, 1'b0, 1'b1, 11'd40, 16'h1111, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 11'd5, 1'b0, 1'b0, 1'b1, 11'd41, 16'h7FFF, 1'b0, 1'b0);
        px(1'b0, 11'd0, 1'b0, 1'b0);
        px(1'b1, 11'd41, 1'b0, 1'b0);
        px(1'b1, 11'd40, 1'b0, 1'b0);
        px(1'b0, 11'd0, 1'b0, 1'b0);
        chk_rgb("drop41", 5'd0, 5'd0, 5'd0);
        px(1'b0, 11'd0, 1'b0, 1'b0);
        chk_rgb("keep40", 5'd3, 5'd2, 5'd2);

        // Reset while pending discards the write
        tick(1'b0, 1'b1, 11'd5, 1'b0, 1'b0, 1'b1, 11'd42, 16'h7FFF, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 11'd0, 16'h0000, 1'b0, 1'b0);
        chk("rstpend_busy", {15'd0, CPU_BUSY}, 16'd0);
        px(1'b0, 11'd0, 1'b0, 1'b0);
        px(1'b1, 11'd42, 1'b0, 1'b0);
        px(1'b0, 11'd0, 1'b0, 1'b0);
        px(1'b0, 11'd0, 1'b0, 1'b0);
        chk_rgb("rstpend_ram", 5'd0, 5'd0, 5'd0);
        chk("rstpend_nBLANK", {15'd0, nBLANK}, 16'd1);

        // Grey control
        tick(1'b0, 1'b1, 11'd5, 1'b0, 1'b0, 1'b0, 11'd0, 16'h0000, 1'b1, 1'b1);
        chk("grey_on", {15'd0, nGREY}, 16'd0);
        for (int i = 0; i < 5; i++) px(1'($urandom), 11'($urandom_range(0, 63)), 1'($urandom), 1'($urandom));
        chk("grey_hold", {15'd0, nGREY}, 16'd0);
        tick(1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 11'd0, 16'h0000, 1'b1, 1'b0);
        chk("grey_off", {15'd0, nGREY}, 16'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 7),
                 11'($urandom_range(0, 63)),
                 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) == 0),
                 11'($urandom_range(0, 63)),
                 16'($urandom),
                 ($urandom_range(0, 31) == 0),
                 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
